std_acc_stage: RTL and testbench
================================

# std_acc_stage

Streaming accumulator that sits directly downstream of a `std_add` → `std_reg` datapath. It consumes one WIDTH-bit sample per accepted handshake and sums `COUNT` consecutive samples into one frame result. It presents each result on a valid/ready output port and holds it until the consumer takes it. A sticky carry-out flag travels with each result.

## Interface
Parameters:
- `WIDTH`, 32, data width of samples and result.
- `COUNT`, 4, samples per frame; legal range ≥ 1.

Ports:
- `clk`  input  1  sole clock, all state on rising edge.
- `reset`  input  1  asynchronous, active-low reset; asserting low clears all state immediately.
- `clear`  input  1  synchronous frame abort.
- `in_data`  input  WIDTH  sample from upstream register.
- `in_valid`  input  1  sample present.
- `in_ready`  output  1  stage can accept a sample this cycle.
- `out_data`  output  WIDTH  frame sum, modulo 2^WIDTH.
- `out_ovf`  output  1  at least one carry-out occurred during this frame.
- `out_valid`  output  1  result present.
- `out_ready`  input  1  consumer takes the result this cycle.
- `frame_cnt`  output  CW  samples accepted in current frame; CW = max(1, $clog2(COUNT)).

## Operation
- States:
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - HOLD: `out_valid`=1.
- Accept = `in_valid` & `in_ready`. Transfer = `out_valid` & `out_ready`.
- In ACCUM, on accept:
  - `acc` <= `acc` + `in_data`, truncated to WIDTH.
  - `ovf` <= `ovf` | carry.
  - `frame_cnt`++.
- Frame completion:
  - When an accept occurs with `frame_cnt` == COUNT-1, the summed value and flag load into `out_data`/`out_ovf` and the state goes to HOLD.
  - `acc`, `ovf` and `frame_cnt` reset to 0 on the same edge.
- In HOLD:
  - `out_data`/`out_ovf` stay stable until transfer.
  - On transfer, the state returns to ACCUM.
- `clear`:
  - Overrides all handshakes. `acc`, `ovf` and `frame_cnt` go to 0, the state goes to ACCUM, and `out_valid` goes to 0.
  - Any pending result is discarded.
  - A sample offered that cycle is not consumed, and `in_ready` is 0 while `clear` is high.
- `frame_cnt` wraps to 0 only at frame completion. It never reaches COUNT.
- COUNT=1: every accepted sample is its own frame. `out_data` = `in_data`, `out_ovf` = 0.

## Timing
- Reset values: state ACCUM, `out_data`=0, `out_ovf`=0, `out_valid`=0, `in_ready`=1 (once `reset` deasserts), `frame_cnt`=0, `acc`=0.
- Reset mid-frame discards partial sum and pending result with no handshake.
- Latency: the result is valid one cycle after the accepting edge of the COUNT-th sample.
- Throughput without bypass: COUNT+1 cycles per frame minimum, because HOLD blocks input for at least one cycle.
- `in_ready` depends on state, `clear`, and, with bypass enabled, `out_ready`. It never depends on `in_valid`.
- `out_valid` depends only on registered state. It never drops without a transfer, `clear` or `reset`.

## Configuration
- Macro: `STD_ACC_STAGE_BYPASS_EN`.
- Defined:
  - In HOLD, `in_ready` = `out_ready` (while `clear` is low).
  - A simultaneous transfer and accept pops the result and starts the new frame on the same edge: `acc`=`in_data`, `frame_cnt`=1, state ACCUM.
  - If COUNT=1, the new sample becomes the next result immediately and the state stays HOLD.
  - Sustained throughput is one sample per cycle.
- Undefined: `in_ready`=0 throughout HOLD, giving one bubble per frame.

## Test plan
- Reset then 4 samples 1,2,3,4 with `out_ready`=1 → `out_data`=10, `out_ovf`=0, `out_valid` high for 1 cycle, one cycle after the 4th accept. `frame_cnt` steps 0,1,2,3,0.
- Samples 0xFFFFFFFF,2,0,0 → `out_data`=1, `out_ovf`=1. The next frame of 1,1,1,1 gives 4 with `out_ovf`=0.
- Backpressure: complete frame 5,5,5,5 with `out_ready`=0 for 6 cycles → `out_data`=20 stable, `in_ready` stays 0 (bypass off). Then pulse `out_ready`=1 → ACCUM next cycle.
- `clear` after 2 samples 7,7, then samples 1,1,1,1 → result 4. `clear` while in HOLD → `out_valid` drops next cycle and no transfer is observed.
- Async reset asserted mid-frame (between clock edges) → `out_valid`, `frame_cnt` and `out_data` read 0 before the next edge.
- With `STD_ACC_STAGE_BYPASS_EN`, `in_valid` and `out_ready` tied high, COUNT=4, samples 1..8 back-to-back → results 10 and 26, no input bubble. Without the macro, the same stimulus shows one cycle of `in_ready`=0 per frame.

Source files
------------

// File: rtl/std_acc_stage.sv
// std_acc_stage: streaming frame accumulator with a valid/ready result port.
// Sums COUNT consecutive accepted samples into one result with a sticky carry flag.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - asynchronous active-low reset
//   clear      - synchronous frame abort; overrides all handshakes
//   in_data    - sample from the upstream register
//   in_valid   - sample present
//   in_ready   - stage can accept a sample this cycle
//   out_data   - frame sum modulo 2^WIDTH
//   out_ovf    - at least one carry-out occurred during the frame
//   out_valid  - result present
//   out_ready  - consumer takes the result this cycle
//   frame_cnt  - samples accepted in the current frame
//
// Optional feature macro: STD_ACC_STAGE_BYPASS_EN
//   When defined, a sample may be accepted in the same cycle that the held
//   result is taken, giving one sample per cycle sustained throughput.
//   When undefined, input is blocked while a result is held.

module std_acc_stage #(
    parameter int WIDTH = 32,
    parameter int COUNT = 4,
    localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    frame_cnt
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_ovf;

    logic [WIDTH:0]   w_sum;
    logic             w_accept;
    logic             w_xfer;
    logic             w_last;
    logic             w_in_rdy;

    // acc/ovf/cnt are zero whenever the stage is in HOLD, so a bypassed
    // accept in HOLD naturally starts a fresh frame through the same adder.
    assign w_sum  = {1'b0, r_acc} + {1'b0, in_data};
    assign w_last = (r_cnt == CW'(COUNT - 1));

`ifdef STD_ACC_STAGE_BYPASS_EN
    assign w_in_rdy = !clear && ((r_state == ACCUM) || out_ready);
`else
    assign w_in_rdy = !clear && (r_state == ACCUM);
`endif

    assign w_accept = in_valid && w_in_rdy;
    assign w_xfer   = (r_state == HOLD) && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ACCUM;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
        end else if (clear) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            // A pop returns to ACCUM unless the same edge completes a frame.
            if (w_xfer) begin
                r_state <= ACCUM;
            end
            if (w_accept) begin
                if (w_last) begin
                    r_out_data <= w_sum[WIDTH-1:0];
                    r_out_ovf  <= r_ovf | w_sum[WIDTH];
                    r_state    <= HOLD;
                    r_acc      <= '0;
                    r_ovf      <= 1'b0;
                    r_cnt      <= '0;
                end else begin
                    r_acc <= w_sum[WIDTH-1:0];
                    r_ovf <= r_ovf | w_sum[WIDTH];
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign in_ready  = w_in_rdy;
    assign out_valid = (r_state == HOLD);
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;
    assign frame_cnt = r_cnt;

endmodule

// File: tb/tb_std_acc_stage.sv
// tb_std_acc_stage: scoreboard bench for std_acc_stage (WIDTH=32, COUNT=4).
// Stimulus pushes expected frame results; a monitor pops on each transfer.

module tb_std_acc_stage;

    localparam int WIDTH = 32;
    localparam int COUNT = 4;
    localparam int CW = 2;

    logic             clk;
    logic             reset;
    logic             clear;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    frame_cnt;

    int checks = 0;
    int failures = 0;
    logic [WIDTH:0] exp_q[$];

    std_acc_stage #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_ovf(out_ovf),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge when valid and
    // ready are both high and no clear is pending.
    always @(negedge clk) begin
        if (reset && !clear && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %0h ovf %0b expected none",
                         out_data, out_ovf);
            end else begin
                logic [WIDTH:0] e;
                e = exp_q.pop_front();
                check("result_data", 64'(out_data), 64'(e[WIDTH-1:0]));
                check("result_ovf", 64'(out_ovf), 64'(e[WIDTH]));
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] d);
        bit done;
        done = 0;
        in_data = d;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no accept expected accept of %0h", d);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int bubbles;
        int idx;
        int cyc;
        logic [31:0] s1[4];
        logic [31:0] s2[4];

        reset = 1'b0;
        clear = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycles(2);
        reset = 1'b1;
        cycles(1);

        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);

        // Frame 1,2,3,4 -> 10; frame_cnt steps 1,2,3,0.
        exp_q.push_back({1'b0, 32'd10});
        for (int i = 0; i < 4; i++) begin
            send(32'(i + 1));
            check("frame_cnt_step", 64'(frame_cnt), 64'((i + 1) % 4));
        end
        check("valid_after_4th", 64'(out_valid), 64'd1);
        cycles(1);
        check("valid_one_cycle", 64'(out_valid), 64'd0);

        // Carry-out frame then a clean frame.
        exp_q.push_back({1'b1, 32'd1});
        s1 = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0};
        for (int i = 0; i < 4; i++) send(s1[i]);
        exp_q.push_back({1'b0, 32'd4});
        for (int i = 0; i < 4; i++) send(32'd1);
        cycles(2);

        // Backpressure: result held stable for 6 cycles.
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 32'd20});
        for (int i = 0; i < 4; i++) send(32'd5);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_data", 64'(out_data), 64'd20);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        cycles(1);
        check("bp_released_valid", 64'(out_valid), 64'd0);
        check("bp_released_ready", 64'(in_ready), 64'd1);

        // Clear mid-frame discards the partial sum of 7,7.
        send(32'd7);
        send(32'd7);
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = 32'd100;
        @(negedge clk);
        check("clear_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        check("clear_frame_cnt", 64'(frame_cnt), 64'd0);
        exp_q.push_back({1'b0, 32'd4});
        for (int i = 0; i < 4; i++) send(32'd1);
        cycles(2);

        // Clear while holding a result: it is discarded, never transferred.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'd9);
        check("hold_before_clear", 64'(out_valid), 64'd1);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        check("clear_drops_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        cycles(2);
        check("no_transfer_after_clear", 64'(exp_q.size()), 64'd0);

        // Async reset between edges mid-frame.
        send(32'd3);
        send(32'd3);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_frame_cnt", 64'(frame_cnt), 64'd0);
        check("async_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        cycles(1);
        check("post_reset_ready", 64'(in_ready), 64'd1);
        exp_q.push_back({1'b0, 32'd8});
        for (int i = 0; i < 4; i++) send(32'd2);
        cycles(2);

        // Back-to-back stream 1..8 with valid and ready held high.
        exp_q.push_back({1'b0, 32'd10});
        exp_q.push_back({1'b0, 32'd26});
        s2 = '{32'd0, 32'd0, 32'd0, 32'd0};
        bubbles = 0;
        idx = 0;
        cyc = 0;
        in_valid = 1'b1;
        in_data = 32'd1;
        while (idx < 8 && cyc < 40) begin
            @(negedge clk);
            if (in_ready) idx++;
            else bubbles++;
            @(posedge clk);
            #1;
            in_data = 32'(idx + 1);
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_done", 64'(idx), 64'd8);
`ifdef STD_ACC_STAGE_BYPASS_EN
        check("stream_bubbles", 64'(bubbles), 64'd0);
`else
        check("stream_bubbles", 64'(bubbles), 64'd1);
`endif
        cycles(3);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
